// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller and its neighbours
// in the CP0 slice.
package irq_ctrl_pkg;

   localparam int IRQ_NSRC = 4;
   localparam int IRQ_IDW  = 2;
   localparam int CFG_DW   = 32;

   // Config register map
   localparam logic [1:0] CFG_ADDR_MASK  = 2'd0;
   localparam logic [1:0] CFG_ADDR_PEND  = 2'd1;
   localparam logic [1:0] CFG_ADDR_CAUSE = 2'd2;
   localparam logic [1:0] CFG_ADDR_RAW   = 2'd3;

   // Controller state encoding
   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_e;

   // One-hot vector selecting source idx
   function automatic logic [IRQ_NSRC-1:0] irq_onehot(input logic [IRQ_IDW-1:0] idx);
      irq_onehot = {{(IRQ_NSRC-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module irq_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top so the lowest set index is the last one to win
   always_comb begin
      idx   = {IW{1'b0}};
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         idx = req[i] ? IW'(i) : idx;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captured pending bits, mask, and a
// single-level request/service handshake towards CP0.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = IRQ_NSRC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NSRC-1:0]     irq_src,
   input  logic                ir_en,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_waddr,
   input  logic [CFG_DW-1:0]   cfg_wdata,
   input  logic [1:0]          cfg_raddr,
   output logic [CFG_DW-1:0]   cfg_rdata,
   input  logic                ack,
   input  logic                eret,
   output logic                ir_out,
   output logic [IRQ_IDW-1:0]  irq_id,
   output logic                in_service
);

   irq_state_e           state_r;
   logic [NSRC-1:0]      mask_r;
   logic [NSRC-1:0]      pending_r;
   logic [NSRC-1:0]      src_prev_r;

   logic [NSRC-1:0]      rise_s;
   logic [NSRC-1:0]      active_s;
   logic [NSRC-1:0]      w1c_s;
   logic [NSRC-1:0]      ack_clr_s;
   logic [NSRC-1:0]      pending_nxt_s;
   logic [IRQ_IDW-1:0]   enc_idx_s;
   logic                 enc_valid_s;
   logic                 wr_mask_s;
   logic                 wr_pend_s;
   logic                 ack_take_s;
   logic                 unused_wdata_s;

   assign rise_s      = irq_src & ~src_prev_r;
   assign active_s    = pending_r & mask_r;
   assign wr_mask_s   = cfg_we && (cfg_waddr == CFG_ADDR_MASK);
   assign wr_pend_s   = cfg_we && (cfg_waddr == CFG_ADDR_PEND);
   assign ack_take_s  = (state_r == IRQ_REQ) && ack;

   // Clears are applied first and new edges OR-ed in last, so an edge
   // arriving together with a W1C or an ack keeps the bit set.
   assign w1c_s         = wr_pend_s  ? cfg_wdata[NSRC-1:0] : {NSRC{1'b0}};
   assign ack_clr_s     = ack_take_s ? irq_onehot(irq_id)  : {NSRC{1'b0}};
   assign pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | rise_s;

   // Upper write-data bits have no storage behind them
   assign unused_wdata_s = ^cfg_wdata[CFG_DW-1:NSRC];

   irq_prio_enc #(
      .N  (NSRC),
      .IW (IRQ_IDW)
   ) u_prio_enc (
      .req   (active_s),
      .idx   (enc_idx_s),
      .valid (enc_valid_s)
   );

   // Edge history, pending and mask registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_prev_r <= {NSRC{1'b0}};
         pending_r  <= {NSRC{1'b0}};
         mask_r     <= {NSRC{1'b0}};
      end else begin
         src_prev_r <= irq_src;
         pending_r  <= pending_nxt_s;
         if (wr_mask_s) begin
            mask_r <= cfg_wdata[NSRC-1:0];
         end
      end
   end

   // Request/service FSM with registered outputs; irq_id is only
   // re-latched on entry to REQ so it stays stable through SERVICE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IRQ_IDLE;
         ir_out     <= 1'b0;
         in_service <= 1'b0;
         irq_id     <= {IRQ_IDW{1'b0}};
      end else begin
         case (state_r)
            IRQ_IDLE: begin
               if (ir_en && enc_valid_s) begin
                  state_r <= IRQ_REQ;
                  ir_out  <= 1'b1;
                  irq_id  <= enc_idx_s;
               end
            end
            IRQ_REQ: begin
               if (ack) begin
                  state_r    <= IRQ_SERVICE;
                  ir_out     <= 1'b0;
                  in_service <= 1'b1;
               end
            end
            IRQ_SERVICE: begin
               if (eret) begin
                  state_r    <= IRQ_IDLE;
                  in_service <= 1'b0;
               end
            end
            default: begin
               state_r    <= IRQ_IDLE;
               ir_out     <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end
   end

   // Config read mux from current register state (same-cycle write not visible)
   always_comb begin
      cfg_rdata = {CFG_DW{1'b0}};
      case (cfg_raddr)
         CFG_ADDR_MASK:  cfg_rdata[NSRC-1:0]  = mask_r;
         CFG_ADDR_PEND:  cfg_rdata[NSRC-1:0]  = pending_r;
         CFG_ADDR_CAUSE: cfg_rdata[IRQ_IDW:0] = {in_service, irq_id};
         CFG_ADDR_RAW:   cfg_rdata[NSRC-1:0]  = irq_src;
         default:        cfg_rdata            = {CFG_DW{1'b0}};
      endcase
   end

endmodule
